// File: rtl/citadel_pkg.sv
// Shared definitions for the UART bridge: FSM state encodings and parameter defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package citadel_pkg;

    // 100 MHz core clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: rd_dat presents the head whenever rd_vld is high.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
//
// Ports: clk/rst (sync active-high), wr_vld/wr_dat push side, rd_ack pop strobe,
//        rd_vld (non-empty) / rd_dat head, drop pulses for one cycle on a lost push.
module byte_fifo
    import citadel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_vld,
    input  logic [7:0] wr_dat,
    input  logic       rd_ack,
    output logic       rd_vld,
    output logic [7:0] rd_dat,
    output logic       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = rd_ack && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = wr_vld && (!full || do_pop);
    assign drop    = wr_vld && full && !do_pop;

    assign rd_vld  = !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through rd_vld.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/uart_bridge.sv
// UART bridge: byte FIFOs in both directions around an 8N1 serial transmitter and receiver.
// Latency: tx_valid to uart_txd start bit is 2 cycles when idle; RX byte appears 1 cycle after the stop-bit sample.
// Backpressure: none; full TX/RX FIFOs drop the incoming byte and set the sticky tx_overflow/rx_overflow flags.
//
// Ports: r_clk, rst (sync active-high); tx_data/tx_valid push into TX FIFO;
//        rx_data/rx_ready/rx_ack pop from RX FIFO; uart_txd/uart_rxd serial pins;
//        tx_overflow, rx_overflow, frame_err sticky error flags (cleared by rst only).
module uart_bridge
    import citadel_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       r_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       tx_overflow,
    output logic       rx_overflow,
    output logic       frame_err
);

    localparam int           CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_pop;
    logic          tx_fifo_vld;
    logic [7:0]    tx_fifo_dat;
    logic          tx_drop;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_END);
    // The head is consumed when idle, or at the end of a stop bit so frames run back to back.
    assign tx_pop = tx_fifo_vld &&
                    ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (r_clk),
        .rst    (rst),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .rd_ack (tx_pop),
        .rd_vld (tx_fifo_vld),
        .rd_dat (tx_fifo_dat),
        .drop   (tx_drop)
    );

    always_ff @(posedge r_clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            // The pin follows the state one cycle later, which keeps every bit
            // exactly CLKS_PER_BIT cycles wide and gives the 2-cycle start latency.
            case (tx_state)
                TX_START: uart_txd <= 1'b0;
                TX_DATA:  uart_txd <= tx_shift[0];
                default:  uart_txd <= 1'b1;
            endcase

            case (tx_state)
                TX_IDLE: begin
                    if (tx_fifo_vld) begin
                        tx_shift <= tx_fifo_dat;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_fifo_vld) begin
                            tx_shift <= tx_fifo_dat;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic          rxd_s1;
    logic          rxd_s2;
    logic          rxd_d;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_stop_smp;
    logic          rx_push;
    logic          rx_drop;
    logic [7:0]    rx_head;

    // Both flops reset to the line's idle level so reset never fakes a start edge.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == BIT_END);
    assign rx_push     = rx_stop_smp && rxd_s2;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (r_clk),
        .rst    (rst),
        .wr_vld (rx_push),
        .wr_dat (rx_shift),
        .rd_ack (rx_ack),
        .rd_vld (rx_ready),
        .rd_dat (rx_head),
        .drop   (rx_drop)
    );

    // Hide stale storage when empty so rx_data reads 0 after reset.
    assign rx_data = rx_ready ? rx_head : 8'h00;

    always_ff @(posedge r_clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_d && !rxd_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the start bit at its middle; a high line is a glitch.
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge r_clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
            rx_overflow <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (tx_drop)                 tx_overflow <= 1'b1;
            if (rx_drop)                 rx_overflow <= 1'b1;
            if (rx_stop_smp && !rxd_s2)  frame_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_bridge.sv
module tb_uart_bridge;

    localparam int CPB = 4;

    logic       r_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       uart_txd;
    logic       uart_rxd = 1'b1;
    logic       tx_overflow;
    logic       rx_overflow;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    logic       mon_s[$];

    uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .r_clk       (r_clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_ack      (rx_ack),
        .uart_txd    (uart_txd),
        .uart_rxd    (uart_rxd),
        .tx_overflow (tx_overflow),
        .rx_overflow (rx_overflow),
        .frame_err   (frame_err)
    );

    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (CPB) tick();
        end
        uart_rxd = 1'b1;
    endtask

    task automatic pop_one();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    // Serial decoder for uart_txd: samples the second cycle of each bit.
    initial begin : tx_mon
        logic [7:0] d;
        int         t0;
        logic       sb;
        forever begin
            tick();
            if (uart_txd === 1'b0) begin
                t0 = cyc;
                tick();
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    d[i] = uart_txd;
                end
                repeat (CPB) tick();
                sb = uart_txd;
                mon_q.push_back(d);
                mon_t.push_back(t0);
                mon_s.push_back(sb);
            end
        end
    end

    initial begin : main
        logic [9:0] pat;
        int         n;
        logic       saw_low;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        check("rst_txd", uart_txd, 1);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_overflow", tx_overflow, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick();

        // ---------------- single TX byte 0x55 ----------------
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx55_lat0", uart_txd, 1);
        tick();
        check("tx55_lat1", uart_txd, 1);
        tick();
        pat = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                check($sformatf("tx55_bit%0d_c%0d", i, j), uart_txd, pat[i]);
                tick();
            end
        end
        for (int j = 0; j < 8; j++) begin
            check("tx55_idle", uart_txd, 1);
            tick();
        end
        check("tx55_mon_count", mon_q.size(), 1);
        if (mon_q.size() > 0) check("tx55_mon_byte", mon_q[0], 8'h55);
        mon_q.delete();
        mon_t.delete();
        mon_s.delete();

        // ---------------- 18 back-to-back pushes ----------------
        for (int k = 0; k < 18; k++) begin
            tx_data  = 8'(k);
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        for (int w = 0; w < 1000 && mon_q.size() < 17; w++) tick();
        check("burst_frames", mon_q.size(), 17);
        n = (mon_q.size() < 17) ? mon_q.size() : 17;
        for (int k = 0; k < n; k++) begin
            check($sformatf("burst_byte%0d", k), mon_q[k], 8'(k));
            check($sformatf("burst_stop%0d", k), mon_s[k], 1);
            if (k > 0) check($sformatf("burst_gap%0d", k), mon_t[k] - mon_t[k-1], 10 * CPB);
        end
        repeat (100) tick();
        check("burst_no_extra", mon_q.size(), 17);
        check("burst_tx_overflow", tx_overflow, 1);
        check("burst_rx_overflow", rx_overflow, 0);
        check("burst_idle_txd", uart_txd, 1);

        // ---------------- RX 0xA3 ----------------
        do_reset();
        check("a3_tx_overflow_cleared", tx_overflow, 0);
        send_frame(8'hA3, 1'b1);
        repeat (3) tick();
        check("a3_rx_ready", rx_ready, 1);
        check("a3_rx_data", rx_data, 8'hA3);
        check("a3_frame_err", frame_err, 0);
        pop_one();
        check("a3_pop_ready", rx_ready, 0);
        check("a3_pop_data", rx_data, 8'h00);

        // ---------------- framing error then good frame ----------------
        send_frame(8'h5A, 1'b0);
        repeat (3) tick();
        check("fe_frame_err", frame_err, 1);
        check("fe_rx_ready", rx_ready, 0);
        pop_one();
        check("fe_ack_ignored", rx_ready, 0);
        send_frame(8'h11, 1'b1);
        repeat (3) tick();
        check("fe_next_ready", rx_ready, 1);
        check("fe_next_data", rx_data, 8'h11);
        check("fe_sticky", frame_err, 1);
        pop_one();
        check("fe_next_pop", rx_ready, 0);

        // ---------------- glitch and RX overflow ----------------
        do_reset();
        check("ovf_frame_err_cleared", frame_err, 0);
        uart_rxd = 1'b0;
        tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        check("glitch_rx_ready", rx_ready, 0);
        check("glitch_frame_err", frame_err, 0);
        for (int k = 0; k < 17; k++) begin
            send_frame(8'h30 + 8'(k), 1'b1);
            repeat (2) tick();
            if (k == 15) check("ovf_before", rx_overflow, 0);
        end
        check("ovf_after", rx_overflow, 1);
        check("ovf_frame_err", frame_err, 0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf_ready%0d", k), rx_ready, 1);
            check($sformatf("ovf_data%0d", k), rx_data, 8'h30 + 8'(k));
            pop_one();
        end
        check("ovf_drained", rx_ready, 0);

        // ---------------- reset mid TX frame ----------------
        do_reset();
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'h0F;
        tick();
        tx_valid = 1'b0;
        repeat (14) tick();
        check("txrst_mid_bit2", uart_txd, 0);
        rst = 1'b1;
        tick();
        check("txrst_txd", uart_txd, 1);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (uart_txd !== 1'b1) saw_low = 1'b1;
        end
        check("txrst_quiet", saw_low, 0);
        check("txrst_tx_overflow", tx_overflow, 0);

        // ---------------- reset mid RX frame ----------------
        uart_rxd = 1'b0;
        repeat (5 * CPB) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_rxd = 1'b1;
        repeat (50) tick();
        check("rxrst_ready", rx_ready, 0);
        check("rxrst_frame_err", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: r_clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entries per direction; power of two, >= 2.
REQ-003 r_clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  byte from the core's IO port.
REQ-006 tx_valid  in  1  push strobe for tx_data; each high cycle is one byte.
REQ-007 rx_data  out  8  head of RX FIFO; valid only while rx_ready=1.
REQ-008 rx_ready  out  1  RX FIFO non-empty.
REQ-009 rx_ack  in  1  pop strobe; each high cycle with rx_ready=1 pops one byte.
REQ-010 uart_txd  out  1  serial out, idle high.
REQ-011 uart_rxd  in  1  asynchronous serial in.
REQ-012 tx_overflow, rx_overflow, frame_err  out  1 each  sticky error flags.

Function
REQ-013 Serial format SHALL be 8N1, LSB first, each bit exactly CLKS_PER_BIT cycles; one frame = 10*CLKS_PER_BIT cycles.
REQ-014 Both FIFOs SHALL be show-ahead; a push is accepted when not full, or when full with a pop in the same cycle; simultaneous push+pop leaves the count unchanged.
REQ-015 A tx_valid push to a full TX FIFO with no same-cycle pop SHALL drop the byte and set tx_overflow.
REQ-016 TX FSM states: IDLE, START, DATA, STOP; IDLE with TX FIFO non-empty SHALL pop the head into a shift register and enter START.
REQ-017 With an idle TX FSM and empty FIFO, uart_txd SHALL fall 2 cycles after the edge sampling tx_valid.
REQ-018 START drives 0, DATA drives shift[0] for 8 bit periods, STOP drives 1; then IDLE, or directly START with no idle gap if the FIFO is non-empty.
REQ-019 uart_txd SHALL be a registered output.
REQ-020 uart_rxd SHALL pass through a 2-flop synchronizer reset to 1; RX FSM uses only the synchronized value.
REQ-021 RX FSM states: IDLE, START, DATA, STOP; IDLE -> START on synchronized 1->0 transition.
REQ-022 START: after CLKS_PER_BIT/2 cycles, sample; 0 -> DATA, 1 -> IDLE (false start, no flag).
REQ-023 DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first; then STOP.
REQ-024 STOP: after CLKS_PER_BIT cycles, sample; 1 pushes the byte, 0 discards it and sets frame_err; both return to IDLE.
REQ-025 An RX push to a full FIFO (no same-cycle pop) SHALL drop the byte and set rx_overflow.
REQ-026 rx_ack while rx_ready=0 SHALL be ignored; rx_ready/rx_data reflect a pop on the next cycle.
REQ-027 Counters SHALL be wide enough for CLKS_PER_BIT-1 and FIFO_DEPTH without wrap; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 Sticky flags SHALL clear only on rst.

Reset
REQ-029 rst SHALL, on the next edge, put both FSMs in IDLE, empty both FIFOs, and drive uart_txd=1, rx_ready=0, rx_data=0, all flags 0.
REQ-030 rst mid-frame SHALL abort the frame without completing it; no partial RX byte is pushed.

Structure
REQ-031 Shared package citadel_pkg SHALL hold the TX/RX state enums and default CLKS_PER_BIT/FIFO_DEPTH constants.
REQ-032 One sub-module byte_fifo (show-ahead, parameterized depth) SHALL be instantiated twice.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16)
REQ-033 tx_valid 1 cycle, tx_data=0x55 -> uart_txd falls 2 cycles later, then 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit, idle 1.
REQ-034 18 back-to-back tx_valid, bytes 0x00..0x11, link idle -> 0x00..0x10 transmitted back to back, 0x11 dropped, tx_overflow=1.
REQ-035 Serial 0xA3 on uart_rxd -> rx_ready=1, rx_data=0xA3; rx_ack 1 cycle -> rx_ready=0 next cycle.
REQ-036 Frame 0x5A with stop bit 0 -> frame_err=1, rx_ready stays 0; next valid frame 0x11 still received.
REQ-037 uart_rxd low for 1 cycle -> no byte, no flag; 17 frames unread -> 16 stored, rx_overflow=1.
REQ-038 rst during DATA of a TX frame -> uart_txd=1 next cycle, no further bits, FIFO empty.
